serial_word_feeder: RTL

- Upstream stage of the 1011 sequence detector: accepts parallel words over a valid/ready handshake and serialises them onto the single-bit `x` line the detector samples.
- Produces gap-free back-to-back frames, plus framing status (`x_valid`, `busy`, `frame_done`).
- All state updates on posedge `clk`. The detector samples `x` on negedge, so `x` is stable half a cycle before capture.

---
 rtl/serial_word_feeder.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_word_feeder.sv
// Serialises parallel words onto a single-bit line with valid/ready intake and gap-free framing.
// Optional even-parity trailer bit is enabled by defining SERIAL_WORD_FEEDER_PARITY_EN.
module serial_word_feeder #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             frame_done
);

`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             last_bit;
    logic             xfer;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Advance so the next bit to send sits at the extraction end.
    function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    always_comb begin
        last_bit  = (state_q == ST_SHIFT) && (cnt_q == '0);
        din_ready = (state_q == ST_IDLE) || last_bit;
        xfer      = din_valid && din_ready;

        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
        parity_d = parity_q;
`endif

        if (xfer) begin
            state_d = ST_SHIFT;
            x_d     = first_bit(din);
            shreg_d = shifted(din);
            cnt_d   = CW'(FRAME_LEN - 1);
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
            parity_d = ^din;
`endif
        end else if (state_q == ST_SHIFT) begin
            if (last_bit) begin
                state_d = ST_IDLE;
                x_d     = 1'b0;
                shreg_d = '0;
            end else begin
                cnt_d   = cnt_q - CW'(1);
                shreg_d = shifted(shreg_q);
                x_d     = first_bit(shreg_q);
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
                // Data exhausted: trailer bit goes out as the final frame bit.
                if (cnt_q == CW'(1)) begin
                    x_d = parity_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b0;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign x          = x_q;
    assign x_valid    = (state_q == ST_SHIFT);
    assign busy       = (state_q == ST_SHIFT);
    assign frame_done = last_bit;

endmodule
